// File: rtl/tausworthe_tester.sv
// Online randomness tester for a 32-bit generator stream: counts ones and runs
// over a block of BLOCK_WORDS words (LSB-first bit order) and flags out-of-range statistics.
module tausworthe_tester #(
  parameter int BLOCK_WORDS = 64,
  parameter int ONES_LO     = 960,
  parameter int ONES_HI     = 1088,
  parameter int RUNS_LO     = 960,
  parameter int RUNS_HI     = 1088
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] data_in,
  input  logic        data_valid,
  output logic        data_ready,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        fail_ones,
  output logic        fail_runs,
  output logic [15:0] ones_count,
  output logic [15:0] runs_count
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] EVAL    = 2'd2;

  localparam logic [10:0] LAST_WORD = 11'(BLOCK_WORDS - 1);
  localparam logic [15:0] ONES_LO_C = 16'(ONES_LO);
  localparam logic [15:0] ONES_HI_C = 16'(ONES_HI);
  localparam logic [15:0] RUNS_LO_C = 16'(RUNS_LO);
  localparam logic [15:0] RUNS_HI_C = 16'(RUNS_HI);

  logic [1:0]  state_q, state_d;
  logic [10:0] word_cnt_q, word_cnt_d;
  logic [15:0] ones_q, ones_d;
  logic [15:0] runs_q, runs_d;
  logic        prev_bit_q, prev_bit_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic        fail_ones_q, fail_ones_d;
  logic        fail_runs_q, fail_runs_d;

  logic        accept;
  logic [30:0] trans;
  logic        boundary;
  logic [5:0]  word_ones;
  logic [5:0]  word_trans;

  function automatic logic [5:0] popcount32(input logic [31:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) begin
      c = c + {5'd0, v[i]};
    end
    return c;
  endfunction

  assign data_ready = (state_q == COLLECT);
  assign busy       = (state_q != IDLE);
  assign accept     = data_ready & data_valid;

  // The first word of a block has no predecessor, so no boundary transition is counted.
  assign trans      = data_in[31:1] ^ data_in[30:0];
  assign boundary   = (word_cnt_q != 11'd0) & (data_in[0] ^ prev_bit_q);
  assign word_ones  = popcount32(data_in);
  assign word_trans = popcount32({1'b0, trans});

  always_comb begin
    state_d     = state_q;
    word_cnt_d  = word_cnt_q;
    ones_d      = ones_q;
    runs_d      = runs_q;
    prev_bit_d  = prev_bit_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    fail_ones_d = fail_ones_q;
    fail_runs_d = fail_runs_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          ones_d      = '0;
          runs_d      = 16'd1;
          word_cnt_d  = '0;
          pass_d      = 1'b0;
          fail_ones_d = 1'b0;
          fail_runs_d = 1'b0;
          state_d     = COLLECT;
        end
      end
      COLLECT: begin
        if (accept) begin
          ones_d     = ones_q + {10'd0, word_ones};
          runs_d     = runs_q + {10'd0, word_trans} + {15'd0, boundary};
          prev_bit_d = data_in[31];
          word_cnt_d = word_cnt_q + 11'd1;
          if (word_cnt_q == LAST_WORD) begin
            state_d = EVAL;
          end
        end
      end
      EVAL: begin
        fail_ones_d = (ones_q < ONES_LO_C) || (ones_q > ONES_HI_C);
        fail_runs_d = (runs_q < RUNS_LO_C) || (runs_q > RUNS_HI_C);
        pass_d      = !(fail_ones_d || fail_runs_d);
        done_d      = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      word_cnt_q  <= '0;
      ones_q      <= '0;
      runs_q      <= '0;
      prev_bit_q  <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_ones_q <= 1'b0;
      fail_runs_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_cnt_q  <= word_cnt_d;
      ones_q      <= ones_d;
      runs_q      <= runs_d;
      prev_bit_q  <= prev_bit_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_ones_q <= fail_ones_d;
      fail_runs_q <= fail_runs_d;
    end
  end

  assign done       = done_q;
  assign pass       = pass_q;
  assign fail_ones  = fail_ones_q;
  assign fail_runs  = fail_runs_q;
  assign ones_count = ones_q;
  assign runs_count = runs_q;

endmodule

// File: tb/tb_tausworthe_tester.sv
// Directed bench for tausworthe_tester with a 2-word block and narrow limits;
// inputs change and outputs are sampled on the falling clock edge.
module tb_tausworthe_tester;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] data_in;
  logic        data_valid;
  logic        data_ready;
  logic        busy;
  logic        done;
  logic        pass;
  logic        fail_ones;
  logic        fail_runs;
  logic [15:0] ones_count;
  logic [15:0] runs_count;

  int checks = 0;
  int errors = 0;

  tausworthe_tester #(
    .BLOCK_WORDS(2),
    .ONES_LO(28),
    .ONES_HI(36),
    .RUNS_LO(6),
    .RUNS_HI(40)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .data_in(data_in),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .busy(busy),
    .done(done),
    .pass(pass),
    .fail_ones(fail_ones),
    .fail_runs(fail_runs),
    .ones_count(ones_count),
    .runs_count(runs_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse start for one cycle; afterwards the block must be collecting.
  task automatic start_block(input string tag);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    check({tag, "_ready"}, {31'd0, data_ready}, 32'd1);
  endtask

  task automatic push_word(input logic [31:0] w);
    data_in    = w;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  // Called at the falling edge right after the last accepting edge (FSM in EVAL).
  task automatic finish_block(input string tag, input logic [15:0] e_ones, input logic [15:0] e_runs,
                              input logic e_fo, input logic e_fr, input logic e_pass);
    check({tag, "_eval_done"}, {31'd0, done}, 32'd0);
    check({tag, "_eval_ready"}, {31'd0, data_ready}, 32'd0);
    check({tag, "_ones"}, {16'd0, ones_count}, {16'd0, e_ones});
    check({tag, "_runs"}, {16'd0, runs_count}, {16'd0, e_runs});
    @(negedge clk);
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
    check({tag, "_fail_ones"}, {31'd0, fail_ones}, {31'd0, e_fo});
    check({tag, "_fail_runs"}, {31'd0, fail_runs}, {31'd0, e_fr});
    check({tag, "_pass"}, {31'd0, pass}, {31'd0, e_pass});
  endtask

  initial begin
    logic [31:0] rw [2];
    int acc;
    logic rdy;

    rst        = 1'b0;
    start      = 1'b0;
    data_in    = '0;
    data_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ready", {31'd0, data_ready}, 32'd0);
    check("rst_runs", {16'd0, runs_count}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Data_valid before start consumes nothing.
    data_in    = 32'hFFFFFFFF;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    check("idle_ones", {16'd0, ones_count}, 32'd0);

    // Block 1: balanced word pattern, passes.
    start_block("b1");
    check("b1_start_ones", {16'd0, ones_count}, 32'd0);
    check("b1_start_runs", {16'd0, runs_count}, 32'd1);
    push_word(32'h00FF00FF);
    push_word(32'h00FF00FF);
    finish_block("b1", 16'd32, 16'd8, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("b1_done_clear", {31'd0, done}, 32'd0);
    repeat (3) @(negedge clk);
    check("b1_hold_runs", {16'd0, runs_count}, 32'd8);
    check("b1_hold_pass", {31'd0, pass}, 32'd1);

    // Block 2: alternating bits, too many runs.
    start_block("b2");
    push_word(32'h55555555);
    push_word(32'h55555555);
    finish_block("b2", 16'd32, 16'd64, 1'b0, 1'b1, 1'b0);

    // Start raised during the done cycle is accepted.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("b3_start_in_done_busy", {31'd0, busy}, 32'd1);
    check("b3_start_in_done_runs", {16'd0, runs_count}, 32'd1);
    push_word(32'h00000000);
    push_word(32'h00000000);
    finish_block("b3", 16'd0, 16'd1, 1'b1, 1'b1, 1'b0);
    @(negedge clk);

    // Block 4: randomly gapped valid, start pulsed while collecting.
    start_block("b4");
    rw[0] = 32'h0000FFFF;
    rw[1] = 32'hFFFF0000;
    acc = 0;
    for (int c = 0; c < 80 && acc < 2; c++) begin
      data_in    = rw[acc];
      data_valid = ($urandom_range(0, 1) == 1);
      start      = (c == 1);
      rdy        = data_ready;
      @(negedge clk);
      if (rdy && data_valid) acc++;
    end
    start      = 1'b0;
    data_in    = 32'hFFFFFFFF;
    data_valid = 1'b1;
    check("b4_accepted", acc, 32'd2);
    finish_block("b4", 16'd32, 16'd3, 1'b0, 1'b1, 1'b0);
    data_valid = 1'b0;
    @(negedge clk);
    check("b4_after_ones", {16'd0, ones_count}, 32'd32);

    // Block 5: reset after one accepted word.
    start_block("b5");
    push_word(32'hFFFFFFFF);
    check("b5_partial_ones", {16'd0, ones_count}, 32'd32);
    #1 rst = 1'b0;
    #1;
    check("b5_rst_busy", {31'd0, busy}, 32'd0);
    check("b5_rst_ready", {31'd0, data_ready}, 32'd0);
    check("b5_rst_ones", {16'd0, ones_count}, 32'd0);
    check("b5_rst_runs", {16'd0, runs_count}, 32'd0);
    check("b5_rst_pass", {31'd0, pass}, 32'd0);
    check("b5_rst_fail_runs", {31'd0, fail_runs}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("b5_no_done", {31'd0, done}, 32'd0);
    end

    // Block 6: a fresh block after reset produces clean results.
    start_block("b6");
    push_word(32'h00FF00FF);
    push_word(32'h00FF00FF);
    finish_block("b6", 16'd32, 16'd8, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("b6_done_clear", {31'd0, done}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tausworthe_tester.md
TAUSWORTHE_TESTER -- requirements
Module: tausworthe_tester

Interface
REQ-001 SHALL have parameter BLOCK_WORDS, default 64, the number of 32-bit words per test block (legal range 1..2047).
REQ-002 SHALL have parameter ONES_LO, default 960, the minimum passing ones count.
REQ-003 SHALL have parameter ONES_HI, default 1088, the maximum passing ones count.
REQ-004 SHALL have parameter RUNS_LO, default 960, the minimum passing runs count.
REQ-005 SHALL have parameter RUNS_HI, default 1088, the maximum passing runs count.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: asynchronous active-low reset (rst=0 resets).
REQ-008 SHALL have port start, input, 1 bit: begin a test block.
REQ-009 SHALL have port data_in, input, 32 bits: generator word under test.
REQ-010 SHALL have port data_valid, input, 1 bit: data_in is valid.
REQ-011 SHALL have port data_ready, output, 1 bit: the tester accepts a word this cycle.
REQ-012 SHALL have port busy, output, 1 bit: a block is in progress.
REQ-013 SHALL have port done, output, 1 bit: one-cycle result strobe.
REQ-014 SHALL have port pass, output, 1 bit: both statistics are within limits.
REQ-015 SHALL have ports fail_ones and fail_runs, outputs, 1 bit each: per-test failure flags.
REQ-016 SHALL have ports ones_count and runs_count, outputs, 16 bits each: statistics of the last block.

Function
REQ-017 SHALL implement the FSM states IDLE, COLLECT and EVAL.
REQ-018 SHALL, in IDLE with start=1, clear ones_count, pass and the fail flags, set runs_count=1 and the word counter to 0, and go to COLLECT.
REQ-019 SHALL drive data_ready=1 only in COLLECT; a word is accepted on an edge where data_valid=1 and data_ready=1; data_valid without data_ready consumes nothing.
REQ-020 SHALL, on each accepted word, add popcount(data_in) to ones_count.
REQ-021 SHALL treat the bitstream as LSB-first: bit 0 of a word precedes bit 31, and bit 31 of word n precedes bit 0 of word n+1.
REQ-022 SHALL, on each accepted word, add the number of bit-to-bit transitions to runs_count: popcount(data_in[31:1] ^ data_in[30:0]), plus (data_in[0] ^ stored previous bit 31) for every word except the first of the block.
REQ-023 SHALL store data_in[31] of each accepted word as the previous bit.
REQ-024 SHALL go from COLLECT to EVAL on the edge that accepts word BLOCK_WORDS; counters at that point include that word.
REQ-025 SHALL, on the edge leaving EVAL, register fail_ones=(ones_count<ONES_LO or >ONES_HI), fail_runs=(runs_count<RUNS_LO or >RUNS_HI), pass=!(fail_ones|fail_runs), set done=1 and go to IDLE; done SHALL clear on the following edge.
REQ-026 SHALL make done high exactly one cycle, in the second cycle after the last accepting edge.
REQ-027 SHALL hold pass, fail flags and counts stable from done until the next accepted start.
REQ-028 SHALL drive busy=1 in COLLECT and EVAL, else 0.
REQ-029 SHALL ignore start while busy=1; start during the done cycle is accepted (FSM is already in IDLE).
REQ-030 SHALL use comparisons that are unsigned and 16 bits wide; the counts cannot overflow within the legal BLOCK_WORDS range.

Reset
REQ-031 SHALL, while rst=0, immediately force IDLE with data_ready=0, busy=0, done=0, pass=0, fail_ones=0, fail_runs=0, ones_count=0, runs_count=0, word counter=0 and previous bit=0.
REQ-032 SHALL, when rst is asserted mid-block, discard the partial block; no done pulse SHALL follow.

Verification (bench: BLOCK_WORDS=2, ONES_LO=28, ONES_HI=36, RUNS_LO=6, RUNS_HI=40)
REQ-033 SHALL verify: start; words 0x00FF00FF, 0x00FF00FF -> ones=32, runs=8, pass=1, fail flags 0, done for 1 cycle.
REQ-034 SHALL verify: start; words 0x55555555 x2 -> ones=32, runs=64, fail_runs=1, fail_ones=0, pass=0.
REQ-035 SHALL verify: start; words 0x00000000 x2 -> ones=0, runs=1, fail_ones=1, fail_runs=1, pass=0.
REQ-036 SHALL verify: data_valid toggled randomly with 0x0000FFFF, 0xFFFF0000 -> exactly 2 words accepted, ones=32, runs=3, fail_runs=1; start pulsed during COLLECT has no effect.
REQ-037 SHALL verify: rst=0 after 1 word accepted -> all outputs 0 immediately; no done; a new start then yields results for a fresh block.
